// File: rtl/kl_fetch_pkg.sv
// Shared fetch-side types: instruction pair bundle and
// the NOP encoding used by fetch, hazard and decode.
package kl_fetch_pkg;

  localparam int unsigned PAIR_BYTES = 8;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] p0;
    logic [31:0] p1;
  } instr_pair_t;

endpackage

// File: rtl/fetch_pair_fifo.sv
// Instruction-pair FIFO with synchronous clear and
// simultaneous push/pop; head is presented combinationally.
module fetch_pair_fifo
  import kl_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_clr,
  input  logic                         i_push,
  input  instr_pair_t                  i_data,
  input  logic                         i_pop,
  output instr_pair_t                  o_head,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  instr_pair_t       r_mem [DEPTH];
  logic [AW-1:0]     r_rd;
  logic [AW-1:0]     r_wr;
  logic [CW-1:0]     r_count;
  logic              w_pop;

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign w_pop   = i_pop && o_valid;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clr) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      // when full, a push lands in the slot being popped
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_issue_buffer.sv
// Fetch front end: PC generation, pair requests to a 1-cycle
// imem, and a stall-absorbing FIFO flushed on redirect.
module fetch_issue_buffer
  import kl_fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_in,
  input  logic                        redirect_in,
  input  logic [31:0]                 redirect_pc_in,
  output logic                        imem_req_out,
  output logic [31:0]                 imem_addr_out,
  input  logic [63:0]                 imem_data_in,
  output logic                        dec_valid_out,
  output logic [31:0]                 dec_p0_instr_out,
  output logic [31:0]                 dec_p1_instr_out,
  output logic [31:0]                 dec_pc_out,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count_out
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]  r_pc;
  logic [31:0]  r_req_pc;
  logic         r_inflight;
  logic         r_epoch;
  logic         r_req_epoch;
  logic         r_squash;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_occ;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  instr_pair_t   w_in;
  instr_pair_t   w_head;
  logic          w_unused_bits;

  assign w_unused_bits = ^redirect_pc_in[1:0];

  // outstanding response counts as occupied so the FIFO never overflows
  assign w_occ  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_req  = !rst && !redirect_in
               && (w_occ < (CW+1)'(DEPTH));
  assign w_push = r_inflight && (r_req_epoch == r_epoch)
               && !redirect_in && !rst;
  assign w_pop  = w_valid && !stall_in;

  assign w_in.pc = r_req_pc;
  assign w_in.p0 = r_squash ? NOP_INSTR : imem_data_in[31:0];
  assign w_in.p1 = imem_data_in[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_req_pc    <= '0;
      r_inflight  <= 1'b0;
      r_epoch     <= 1'b0;
      r_req_epoch <= 1'b0;
      r_squash    <= 1'b0;
    end else if (redirect_in) begin
      r_pc       <= {redirect_pc_in[31:3], 3'b000};
      r_squash   <= redirect_pc_in[2];
      r_inflight <= 1'b0;
      r_epoch    <= ~r_epoch;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc        <= r_pc + 32'(PAIR_BYTES);
        r_req_pc    <= r_pc;
        r_req_epoch <= r_epoch;
      end
      if (w_push) begin
        r_squash <= 1'b0;
      end
    end
  end

  fetch_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst   (rst),
    .i_clr   (redirect_in),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign imem_req_out     = w_req;
  assign imem_addr_out    = r_pc;
  assign dec_valid_out    = w_valid;
  assign dec_p0_instr_out = w_head.p0;
  assign dec_p1_instr_out = w_head.p1;
  assign dec_pc_out       = w_head.pc;
  assign fifo_count_out   = w_count;

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// Directed bench for fetch_issue_buffer: free run, stall,
// redirects, mid-run reset and drain from full.
module tb_fetch_issue_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic [63:0] imem_data_in;
  logic        dec_valid_out;
  logic [31:0] dec_p0_instr_out;
  logic [31:0] dec_p1_instr_out;
  logic [31:0] dec_pc_out;
  logic [2:0]  fifo_count_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  fetch_issue_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .stall_in         (stall_in),
    .redirect_in      (redirect_in),
    .redirect_pc_in   (redirect_pc_in),
    .imem_req_out     (imem_req_out),
    .imem_addr_out    (imem_addr_out),
    .imem_data_in     (imem_data_in),
    .dec_valid_out    (dec_valid_out),
    .dec_p0_instr_out (dec_p0_instr_out),
    .dec_p1_instr_out (dec_p1_instr_out),
    .dec_pc_out       (dec_pc_out),
    .fifo_count_out   (fifo_count_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // synchronous imem, 1-cycle latency
  always @(posedge clk) begin
    if (imem_req_out)
      imem_data_in <= {ins(imem_addr_out + 32'd4), ins(imem_addr_out)};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req_out !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b exp 0", imem_req_out);
    end
    checks++;
    if (dec_valid_out !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b exp 0", dec_valid_out);
    end
    checks++;
    if (fifo_count_out !== 3'd0) begin
      errors++; $display("FAIL rst_count got %0d exp 0", fifo_count_out);
    end
    checks++;
    if ({dec_pc_out, dec_p0_instr_out, dec_p1_instr_out} !== 96'h0) begin
      errors++;
      $display("FAIL rst_head got %h %h %h exp 0",
               dec_pc_out, dec_p0_instr_out, dec_p1_instr_out);
    end
  endtask

  task automatic test_free_run();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      errors++;
      $display("FAIL run_first_req got %b %h exp 1 0", imem_req_out, imem_addr_out);
    end
    tick();
    checks++;
    if (dec_valid_out !== 1'b0 || imem_addr_out !== 32'h8) begin
      errors++;
      $display("FAIL run_c2 got v%b a%h exp v0 a8", dec_valid_out, imem_addr_out);
    end
    tick();
    exp_pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dec_valid_out !== 1'b1 || dec_pc_out !== exp_pc ||
          dec_p0_instr_out !== ins(exp_pc) ||
          dec_p1_instr_out !== ins(exp_pc + 32'd4)) begin
        errors++;
        $display("FAIL run_pair got v%b pc%h p0 %h p1 %h exp pc%h",
                 dec_valid_out, dec_pc_out, dec_p0_instr_out,
                 dec_p1_instr_out, exp_pc);
      end
      exp_pc += 32'd8;
      tick();
    end
  endtask

  task automatic test_stall();
    stall_in = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dec_valid_out !== 1'b1 || dec_pc_out !== exp_pc) begin
        errors++;
        $display("FAIL stall_hold got v%b pc%h exp v1 pc%h",
                 dec_valid_out, dec_pc_out, exp_pc);
      end
    end
    checks++;
    if (fifo_count_out !== 3'd4 || imem_req_out !== 1'b0) begin
      errors++;
      $display("FAIL stall_full got cnt%0d req%b exp cnt4 req0",
               fifo_count_out, imem_req_out);
    end
    stall_in = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dec_valid_out !== 1'b1 || dec_pc_out !== exp_pc ||
          dec_p0_instr_out !== ins(exp_pc)) begin
        errors++;
        $display("FAIL stall_release got v%b pc%h p0 %h exp pc%h",
                 dec_valid_out, dec_pc_out, dec_p0_instr_out, exp_pc);
      end
      exp_pc += 32'd8;
      tick();
    end
  endtask

  task automatic test_redirect();
    logic found;
    logic prev;
    found = 1'b0;
    stall_in = 1'b1;
    #1;
    prev = imem_req_out;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (fifo_count_out == 3'd3 && prev) begin
        found = 1'b1;
        break;
      end
      prev = imem_req_out;
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL redir_setup got %b exp 1 (count3+inflight)", found);
    end
    redirect_in = 1'b1;
    redirect_pc_in = 32'h0000_0104;
    stall_in = 1'b0;
    #1;
    checks++;
    if (imem_req_out !== 1'b0) begin
      errors++; $display("FAIL redir_noreq got %b exp 0", imem_req_out);
    end
    tick();
    redirect_in = 1'b0;
    #1;
    checks++;
    if (fifo_count_out !== 3'd0 || dec_valid_out !== 1'b0 ||
        imem_req_out !== 1'b1 || imem_addr_out !== 32'h100) begin
      errors++;
      $display("FAIL redir_flush got cnt%0d v%b req%b a%h exp 0 0 1 100",
               fifo_count_out, dec_valid_out, imem_req_out, imem_addr_out);
    end
    tick();
    checks++;
    if (dec_valid_out !== 1'b0 || imem_addr_out !== 32'h108) begin
      errors++;
      $display("FAIL redir_bubble got v%b a%h exp v0 a108", dec_valid_out, imem_addr_out);
    end
    tick();
    checks++;
    if (dec_valid_out !== 1'b1 || dec_pc_out !== 32'h100 ||
        dec_p0_instr_out !== 32'h0 || dec_p1_instr_out !== ins(32'h104)) begin
      errors++;
      $display("FAIL redir_squash got v%b pc%h p0 %h p1 %h exp 1 100 0 %h",
               dec_valid_out, dec_pc_out, dec_p0_instr_out,
               dec_p1_instr_out, ins(32'h104));
    end
    tick();
    checks++;
    if (dec_valid_out !== 1'b1 || dec_pc_out !== 32'h108 ||
        dec_p0_instr_out !== ins(32'h108)) begin
      errors++;
      $display("FAIL redir_next got v%b pc%h p0 %h exp 1 108 %h",
               dec_valid_out, dec_pc_out, dec_p0_instr_out, ins(32'h108));
    end
    tick();
    exp_pc = 32'h110;
  endtask

  task automatic test_redirect_stall();
    checks++;
    if (dec_valid_out !== 1'b1 || dec_pc_out !== exp_pc) begin
      errors++;
      $display("FAIL rs_head got v%b pc%h exp 1 %h", dec_valid_out, dec_pc_out, exp_pc);
    end
    stall_in = 1'b1;
    redirect_in = 1'b1;
    redirect_pc_in = 32'h0000_0200;
    #1;
    checks++;
    if (imem_req_out !== 1'b0) begin
      errors++; $display("FAIL rs_noreq got %b exp 0", imem_req_out);
    end
    tick();
    redirect_in = 1'b0;
    stall_in = 1'b0;
    #1;
    checks++;
    if (fifo_count_out !== 3'd0 || dec_valid_out !== 1'b0 ||
        imem_req_out !== 1'b1 || imem_addr_out !== 32'h200) begin
      errors++;
      $display("FAIL rs_flush got cnt%0d v%b req%b a%h exp 0 0 1 200",
               fifo_count_out, dec_valid_out, imem_req_out, imem_addr_out);
    end
    tick();
    checks++;
    if (dec_valid_out !== 1'b0) begin
      errors++; $display("FAIL rs_bubble got %b exp 0", dec_valid_out);
    end
    tick();
    checks++;
    if (dec_valid_out !== 1'b1 || dec_pc_out !== 32'h200 ||
        dec_p0_instr_out !== ins(32'h200) ||
        dec_p1_instr_out !== ins(32'h204)) begin
      errors++;
      $display("FAIL rs_pair got v%b pc%h p0 %h p1 %h exp 1 200",
               dec_valid_out, dec_pc_out, dec_p0_instr_out, dec_p1_instr_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    redirect_in = 1'b1;
    redirect_pc_in = 32'h0000_0300;
    tick();
    redirect_pc_in = 32'h0000_0404;
    #1;
    checks++;
    if (dec_valid_out !== 1'b0 || imem_req_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got v%b req%b exp 0 0", dec_valid_out, imem_req_out);
    end
    tick();
    redirect_in = 1'b0;
    #1;
    checks++;
    if (fifo_count_out !== 3'd0 || dec_valid_out !== 1'b0 ||
        imem_req_out !== 1'b1 || imem_addr_out !== 32'h400) begin
      errors++;
      $display("FAIL b2b_req got cnt%0d v%b req%b a%h exp 0 0 1 400",
               fifo_count_out, dec_valid_out, imem_req_out, imem_addr_out);
    end
    tick();
    tick();
    checks++;
    if (dec_valid_out !== 1'b1 || dec_pc_out !== 32'h400 ||
        dec_p0_instr_out !== 32'h0 || dec_p1_instr_out !== ins(32'h404)) begin
      errors++;
      $display("FAIL b2b_pair got v%b pc%h p0 %h p1 %h exp 1 400 0 %h",
               dec_valid_out, dec_pc_out, dec_p0_instr_out,
               dec_p1_instr_out, ins(32'h404));
    end
    tick();
    checks++;
    if (dec_valid_out !== 1'b1 || dec_pc_out !== 32'h408 ||
        dec_p0_instr_out !== ins(32'h408)) begin
      errors++;
      $display("FAIL b2b_next got v%b pc%h p0 %h exp 1 408 %h",
               dec_valid_out, dec_pc_out, dec_p0_instr_out, ins(32'h408));
    end
    tick();
  endtask

  task automatic test_rst_full();
    logic found;
    found = 1'b0;
    stall_in = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fifo_count_out == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1 || imem_req_out !== 1'b0) begin
      errors++;
      $display("FAIL rf_fill got full%b req%b exp 1 0", found, imem_req_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (imem_req_out !== 1'b0 || dec_valid_out !== 1'b0 ||
        fifo_count_out !== 3'd0 || dec_pc_out !== 32'h0 ||
        dec_p0_instr_out !== 32'h0 || dec_p1_instr_out !== 32'h0) begin
      errors++;
      $display("FAIL rf_reset got req%b v%b cnt%0d pc%h p0 %h p1 %h exp all 0",
               imem_req_out, dec_valid_out, fifo_count_out,
               dec_pc_out, dec_p0_instr_out, dec_p1_instr_out);
    end
    rst = 1'b0;
    stall_in = 1'b0;
    #1;
    checks++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      errors++;
      $display("FAIL rf_restart got req%b a%h exp 1 0", imem_req_out, imem_addr_out);
    end
    tick();
    checks++;
    if (dec_valid_out !== 1'b0) begin
      errors++; $display("FAIL rf_bubble got %b exp 0", dec_valid_out);
    end
    tick();
    checks++;
    if (dec_valid_out !== 1'b1 || dec_pc_out !== 32'h0 ||
        dec_p0_instr_out !== ins(32'h0)) begin
      errors++;
      $display("FAIL rf_pair got v%b pc%h p0 %h exp 1 0 %h",
               dec_valid_out, dec_pc_out, dec_p0_instr_out, ins(32'h0));
    end
    exp_pc = 32'h0;
  endtask

  task automatic test_full_release();
    logic found;
    int   cnts [6];
    cnts = '{4, 3, 2, 2, 2, 2};
    found = 1'b0;
    stall_in = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fifo_count_out == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL fr_fill got %b exp 1", found);
    end
    stall_in = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dec_valid_out !== 1'b1 || dec_pc_out !== exp_pc ||
          dec_p1_instr_out !== ins(exp_pc + 32'd4) ||
          fifo_count_out !== cnts[i][2:0]) begin
        errors++;
        $display("FAIL fr_drain got v%b pc%h cnt%0d exp 1 %h %0d",
                 dec_valid_out, dec_pc_out, fifo_count_out, exp_pc, cnts[i]);
      end
      exp_pc += 32'd8;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    stall_in = 1'b0;
    redirect_in = 1'b0;
    redirect_pc_in = 32'h0;
    imem_data_in = 64'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_rst_full();
    test_full_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
